mult_share_ctrl: RTL and testbench

//  Controller/arbiter that lets two requesters share one iterative unsigned shift-add multiplier.

---
 rtl/mult_share_if.sv | 45 ++++
 rtl/mult_share_ctrl.sv | 129 ++++++++++++
 tb/tb_mult_share_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_if.sv
// mult_share_if
//   Bundles the two requester operand channels, the response channel and the
//   busy flag of the shared multiplier controller.
//   slave  : seen by mult_share_ctrl (consumes requests, produces responses)
//   master : seen by the requesters/consumer side (drives requests, accepts responses)
//   Signals:
//     req0_valid/req0_ready/req0_a/req0_b  requester 0 operand handshake
//     req1_valid/req1_ready/req1_a/req1_b  requester 1 operand handshake
//     resp_valid/resp_ready                product handshake
//     resp_id                              requester that issued the product
//     resp_product                         unsigned a*b, 2*WIDTH bits
//     busy                                 controller not idle
interface mult_share_if #(
    parameter int WIDTH = 4
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_id;
    logic [2*WIDTH-1:0]   resp_product;
    logic                 busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_product, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_product, busy
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Lets two requesters share one iterative unsigned shift-add multiplier.
//   A requester is granted round-robin while idle, its operands are captured,
//   the product is built one multiplier bit per cycle over WIDTH cycles and
//   then presented with the requester id until the consumer accepts it.
//   Ports:
//     clk   rising-edge system clock
//     rst   synchronous active-high reset
//     bus   mult_share_if.slave (request channels, response channel, busy)
module mult_share_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    mult_share_if.slave      bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [2*WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last_grant;
    logic                r_resp_valid;
    logic                r_resp_id;
    logic [2*WIDTH-1:0]  r_resp_product;

    logic                w_grant_vld;
    logic                w_grant_id;
    logic [2*WIDTH-1:0]  w_addend;
    logic [2*WIDTH-1:0]  w_acc_next;

    // Round-robin grant: a lone requester wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = ~r_last_grant;
        end else if (bus.req0_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b0;
        end else if (bus.req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b1;
        end else begin
            w_grant_vld = 1'b0;
            w_grant_id  = 1'b0;
        end
    end

    // Partial product for the current multiplier bit, shifted into place.
    always_comb begin
        w_addend = {(2*WIDTH){1'b0}};
        if (r_b[r_cnt]) begin
            w_addend = {{WIDTH{1'b0}}, r_a} << r_cnt;
        end else begin
            w_addend = {(2*WIDTH){1'b0}};
        end
    end

    assign w_acc_next = r_acc + w_addend;

    // Controller FSM, operand capture, shift-add datapath and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_a            <= {WIDTH{1'b0}};
            r_b            <= {WIDTH{1'b0}};
            r_acc          <= {(2*WIDTH){1'b0}};
            r_cnt          <= {CNT_W{1'b0}};
            r_last_grant   <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_id      <= 1'b0;
            r_resp_product <= {(2*WIDTH){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_a          <= w_grant_id ? bus.req1_a : bus.req0_a;
                        r_b          <= w_grant_id ? bus.req1_b : bus.req0_b;
                        r_acc        <= {(2*WIDTH){1'b0}};
                        r_cnt        <= {CNT_W{1'b0}};
                        r_resp_id    <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_ONE;
                    // The last multiplier bit completes the product on this edge.
                    if (r_cnt == CNT_LAST) begin
                        r_resp_product <= w_acc_next;
                        r_resp_valid   <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready   = (r_state == S_IDLE) && w_grant_vld && !w_grant_id;
    assign bus.req1_ready   = (r_state == S_IDLE) && w_grant_vld &&  w_grant_id;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_id      = r_resp_id;
    assign bus.resp_product = r_resp_product;
    assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
module tb_mult_share_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   model_last;   // requester served most recently, per round-robin rules

    always #5 clk = ~clk;

    mult_share_if #(.WIDTH(W)) bus ();

    mult_share_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = 4'h0; bus.req0_b = 4'h0;
        bus.req1_valid = 1'b0; bus.req1_a = 4'h0; bus.req1_b = 4'h0;
        bus.resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    // Counts falling edges until resp_valid is seen (bounded).
    task automatic wait_resp(output int lat);
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept_resp();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.resp_valid); end
        checks++; if (bus.resp_product !== 8'h00) begin errors++; $display("FAIL rst_product got %h exp 00", bus.resp_product); end
        checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL rst_id got %b exp 0", bus.resp_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", {bus.req0_ready, bus.req1_ready}); end
    endtask

    task automatic test_single();
        bus.req0_valid = 1'b1; bus.req0_a = 4'hF; bus.req0_b = 4'hF;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        model_last = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy cycle %0d got %b exp 1", k, bus.busy); end
            checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid cycle %0d got %b exp 0", k, bus.resp_valid); end
            @(negedge clk);
        end
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.resp_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_done got %b exp 1", bus.busy); end
        checks++; if (bus.resp_product !== 8'hE1) begin errors++; $display("FAIL single_product got %h exp e1", bus.resp_product); end
        checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL single_id got %b exp 0", bus.resp_id); end
        accept_resp();
        checks++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL single_after_accept got %b exp 00", {bus.resp_valid, bus.busy}); end
    endtask

    task automatic test_both_valid();
        int lat;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'h3; bus.req0_b = 4'h5;
        bus.req1_valid = 1'b1; bus.req1_a = 4'h7; bus.req1_b = 4'h6;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL tie_first_ready got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        model_last = 1'b0;
        // Operand change after the handshake must not matter.
        bus.req0_a = 4'hA; bus.req0_b = 4'hA;
        for (int k = 1; k <= 4; k++) begin
            checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL tie_run_ready cycle %0d got %b exp 00", k, {bus.req0_ready, bus.req1_ready}); end
            @(negedge clk);
        end
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL tie_r0_valid got %b exp 1", bus.resp_valid); end
        checks++; if (bus.resp_product !== 8'h0F) begin errors++; $display("FAIL tie_r0_product got %h exp 0f", bus.resp_product); end
        checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL tie_r0_id got %b exp 0", bus.resp_id); end
        accept_resp();
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL tie_second_ready got %b exp 01", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        model_last = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_resp(lat);
        checks++; if (lat !== W) begin errors++; $display("FAIL tie_r1_latency got %0d exp %0d", lat, W); end
        checks++; if (bus.resp_product !== 8'h2A) begin errors++; $display("FAIL tie_r1_product got %h exp 2a", bus.resp_product); end
        checks++; if (bus.resp_id !== 1'b1) begin errors++; $display("FAIL tie_r1_id got %b exp 1", bus.resp_id); end
        accept_resp();
    endtask

    task automatic test_stall();
        int lat;
        bus.req0_valid = 1'b1; bus.req0_a = 4'hD; bus.req0_b = 4'hB;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL stall_ready got %b exp 1", bus.req0_ready); end
        @(negedge clk);
        model_last = 1'b0;
        wait_resp(lat);
        checks++; if (lat !== W) begin errors++; $display("FAIL stall_latency got %0d exp %0d", lat, W); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if ({bus.resp_valid, bus.resp_id, bus.resp_product} !== {1'b1, 1'b0, 8'h8F}) begin
                errors++; $display("FAIL stall_hold cycle %0d got v=%b id=%b p=%h exp v=1 id=0 p=8f", k, bus.resp_valid, bus.resp_id, bus.resp_product);
            end
            checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready cycle %0d got %b exp 0", k, bus.req0_ready); end
        end
        accept_resp();
        checks++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL stall_idle got %b exp 00", {bus.resp_valid, bus.busy}); end
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL stall_reaccept_ready got %b exp 1", bus.req0_ready); end
        // Requester withdraws before the edge: nothing must be issued.
        bus.req0_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL withdraw_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_edges();
        logic [3:0] ta [4] = '{4'h0, 4'h9, 4'h1, 4'hF};
        logic [3:0] tb [4] = '{4'h9, 4'h0, 4'hF, 4'h1};
        logic [7:0] te [4] = '{8'h00, 8'h00, 8'h0F, 8'h0F};
        int lat;
        for (int i = 0; i < 4; i++) begin
            bus.req0_valid = 1'b1; bus.req0_a = ta[i]; bus.req0_b = tb[i];
            @(negedge clk);
            bus.req0_valid = 1'b0;
            model_last = 1'b0;
            wait_resp(lat);
            checks++; if (lat !== W) begin errors++; $display("FAIL edge%0d_latency got %0d exp %0d", i, lat, W); end
            checks++; if (bus.resp_product !== te[i]) begin errors++; $display("FAIL edge%0d_product got %h exp %h", i, bus.resp_product, te[i]); end
            accept_resp();
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        bus.req0_valid = 1'b1; bus.req0_a = 4'hF; bus.req0_b = 4'hF;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        checks++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL abort_state got %b exp 00", {bus.resp_valid, bus.busy}); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid cycle %0d got %b exp 0", k, bus.resp_valid); end
        end
        bus.req0_valid = 1'b1; bus.req0_a = 4'h2; bus.req0_b = 4'h3;
        bus.req1_valid = 1'b1; bus.req1_a = 4'h4; bus.req1_b = 4'h5;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL abort_priority got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        model_last = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_resp(lat);
        checks++; if ({bus.resp_id, bus.resp_product} !== {1'b0, 8'h06}) begin errors++; $display("FAIL abort_next_op got id=%b p=%h exp id=0 p=06", bus.resp_id, bus.resp_product); end
        accept_resp();
    endtask

    task automatic test_random();
        logic [3:0] q0a[$], q0b[$], q1a[$], q1b[$];
        logic [3:0] ea, eb;
        logic [7:0] pv;
        bit v0, v1, g;
        int lat, guard;
        for (int i = 0; i < 256; i++) begin
            pv = 8'(i);
            if (i % 2 == 0) begin q0a.push_back(pv[7:4]); q0b.push_back(pv[3:0]); end
            else            begin q1a.push_back(pv[7:4]); q1b.push_back(pv[3:0]); end
        end
        guard = 0;
        while ((q0a.size() > 0 || q1a.size() > 0) && guard < 400) begin
            guard++;
            v0 = (q0a.size() > 0);
            v1 = (q1a.size() > 0);
            // Occasionally withhold one requester when the other can go.
            if (v0 && v1 && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) v0 = 1'b0; else v1 = 1'b0;
            end
            if (v0 && v1) g = ~model_last;
            else          g = v1;
            bus.req0_valid = v0; if (v0) begin bus.req0_a = q0a[0]; bus.req0_b = q0b[0]; end
            bus.req1_valid = v1; if (v1) begin bus.req1_a = q1a[0]; bus.req1_b = q1b[0]; end
            #1;
            checks++; if ({bus.req1_ready, bus.req0_ready} !== (g ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rnd_grant op %0d got r1r0=%b exp grant %0d", guard, {bus.req1_ready, bus.req0_ready}, g);
            end
            @(negedge clk);
            model_last = g;
            if (g) begin ea = q1a.pop_front(); eb = q1b.pop_front(); end
            else   begin ea = q0a.pop_front(); eb = q0b.pop_front(); end
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom);
            bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom);
            wait_resp(lat);
            checks++; if (lat !== W) begin errors++; $display("FAIL rnd_latency op %0d got %0d exp %0d", guard, lat, W); end
            checks++; if (bus.resp_product !== 8'(ea * eb)) begin errors++; $display("FAIL rnd_product op %0d a=%h b=%h got %h exp %h", guard, ea, eb, bus.resp_product, 8'(ea * eb)); end
            checks++; if (bus.resp_id !== g) begin errors++; $display("FAIL rnd_id op %0d got %b exp %b", guard, bus.resp_id, g); end
            for (int s = $urandom_range(0, 3); s > 0; s--) @(negedge clk);
            checks++; if (bus.resp_product !== 8'(ea * eb)) begin errors++; $display("FAIL rnd_held op %0d got %h exp %h", guard, bus.resp_product, 8'(ea * eb)); end
            accept_resp();
        end
        checks++; if (q0a.size() + q1a.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d left exp 0", q0a.size() + q1a.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both_valid();
        test_stall();
        test_edges();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
